// File: rtl/fp_cvt_128_to_i128_if.sv
// rtl/fp_cvt_128_to_i128_if.sv - operand/result handshake bundle for the binary128-to-int128 converter
interface fp_cvt_128_to_i128_if;
  logic         vld_i;
  logic         rdy_o;
  logic         op;
  logic [2:0]   rm;
  logic [127:0] a;
  logic         vld_o;
  logic         rdy_i;
  logic [127:0] o;
  logic         inexact;
  logic         invalid;

  modport master (
    output vld_i, op, rm, a, rdy_i,
    input  rdy_o, vld_o, o, inexact, invalid
  );

  modport slave (
    input  vld_i, op, rm, a, rdy_i,
    output rdy_o, vld_o, o, inexact, invalid
  );
endinterface

// File: rtl/fp_cvt_128_to_i128.sv
// rtl/fp_cvt_128_to_i128.sv - 3-stage binary128 to 128-bit integer converter with valid/ready stall
// Define FPCVTTOI_SAT_EN to saturate invalid results instead of returning the integer indefinite.
module fp_cvt_128_to_i128 (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  fp_cvt_128_to_i128_if.slave  bus
);
  localparam int FPWID = 128;
  localparam int EMSB  = 14;
  localparam int FMSB  = 111;
  localparam int BIAS  = 16383;

  typedef struct packed {
    logic         vld;
    logic         sign;
    logic         op;
    logic [2:0]   rm;
    logic [15:0]  e;
    logic [112:0] m;
    logic         nan;
    logic         inf;
  } s1_t;

  typedef struct packed {
    logic         vld;
    logic         sign;
    logic         op;
    logic [2:0]   rm;
    logic [127:0] mag;
    logic         ovf;
    logic         g;
    logic         r;
    logic         s;
    logic         nan;
    logic         inf;
  } s2_t;

  s1_t          s1_d, s1_q;
  s2_t          s2_d, s2_q;
  logic         vld_o_d, vld_o_q;
  logic [127:0] o_d, o_q;
  logic         inexact_d, inexact_q;
  logic         invalid_d, invalid_q;

  logic         advance;
  logic [EMSB:0] a_exp;
  logic [FMSB:0] a_sig;

  // Single global stall: every stage moves together or not at all.
  assign advance = ce & (bus.rdy_i | ~vld_o_q);

  always_comb begin
    a_exp = bus.a[FPWID-2:FMSB+1];
    a_sig = bus.a[FMSB:0];
    s1_d  = s1_q;
    if (advance) begin
      s1_d.vld  = bus.vld_i;
      s1_d.sign = bus.a[FPWID-1];
      s1_d.op   = bus.op;
      s1_d.rm   = bus.rm;
      s1_d.e    = {1'b0, a_exp} - 16'(BIAS);
      s1_d.m    = {a_exp != '0, a_sig};
      s1_d.nan  = (&a_exp) & (a_sig != '0);
      s1_d.inf  = (&a_exp) & (a_sig == '0);
    end
  end

  logic signed [15:0] e2;
  logic [7:0]         lsh;
  logic [7:0]         rsh;
  logic [143:0]       wide_l;
  logic [225:0]       wide_r;

  always_comb begin
    e2     = $signed(s1_q.e);
    lsh    = '0;
    rsh    = '0;
    wide_l = '0;
    wide_r = '0;
    s2_d   = s2_q;
    if (advance) begin
      s2_d.vld  = s1_q.vld;
      s2_d.sign = s1_q.sign;
      s2_d.op   = s1_q.op;
      s2_d.rm   = s1_q.rm;
      s2_d.nan  = s1_q.nan;
      s2_d.inf  = s1_q.inf;
      s2_d.mag  = '0;
      s2_d.ovf  = 1'b0;
      s2_d.g    = 1'b0;
      s2_d.r    = 1'b0;
      s2_d.s    = 1'b0;
      if (e2 >= 16'sd128) begin
        s2_d.ovf = 1'b1;
      end else if (e2 >= 16'sd112) begin
        lsh      = 8'(e2 - 16'sd112);
        wide_l   = {31'b0, s1_q.m} << lsh;
        s2_d.mag = wide_l[127:0];
        s2_d.ovf = |wide_l[143:128];
      end else if (e2 >= -16'sd1) begin
        // Fraction bits land below bit 113: [113]=g, [112]=r, rest=sticky.
        rsh      = 8'(16'sd112 - e2);
        wide_r   = {s1_q.m, 113'b0} >> rsh;
        s2_d.mag = {15'b0, wide_r[225:113]};
        s2_d.g   = wide_r[113];
        s2_d.r   = wide_r[112];
        s2_d.s   = |wide_r[111:0];
      end else begin
        s2_d.s = |s1_q.m;
      end
    end
  end

  logic         inc;
  logic [128:0] mag_r;
  logic         ovf_any;
  logic         inv;
  logic [127:0] res;
  logic [127:0] sat;

  always_comb begin
    case (s2_q.rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (s2_q.r | s2_q.s) & ~s2_q.sign;
      3'd3:    inc = (s2_q.r | s2_q.s) & s2_q.sign;
      3'd4:    inc = s2_q.r | s2_q.s;
      default: inc = s2_q.r & (s2_q.g | s2_q.s);
    endcase
    mag_r   = {1'b0, s2_q.mag} + 129'(inc);
    ovf_any = s2_q.ovf | mag_r[128];
    if (s2_q.nan | s2_q.inf | ovf_any)
      inv = 1'b1;
    else if (s2_q.op)
      inv = s2_q.sign ? (mag_r[127] & (|mag_r[126:0])) : mag_r[127];
    else
      inv = s2_q.sign & (mag_r[127:0] != '0);
    res = s2_q.sign ? -mag_r[127:0] : mag_r[127:0];
`ifdef FPCVTTOI_SAT_EN
    if (s2_q.nan | ~s2_q.sign)
      sat = s2_q.op ? {1'b0, {127{1'b1}}} : {128{1'b1}};
    else
      sat = s2_q.op ? {1'b1, 127'b0} : 128'b0;
`else
    sat = {1'b1, 127'b0};
`endif
    vld_o_d   = vld_o_q;
    o_d       = o_q;
    inexact_d = inexact_q;
    invalid_d = invalid_q;
    if (advance) begin
      vld_o_d = s2_q.vld;
      if (s2_q.vld) begin
        o_d       = inv ? sat : res;
        invalid_d = inv;
        inexact_d = ~inv & (s2_q.r | s2_q.s);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      vld_o_q   <= 1'b0;
      o_q       <= '0;
      inexact_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      vld_o_q   <= vld_o_d;
      o_q       <= o_d;
      inexact_q <= inexact_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.rdy_o   = advance;
  assign bus.vld_o   = vld_o_q;
  assign bus.o       = o_q;
  assign bus.inexact = inexact_q;
  assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_fp_cvt_128_to_i128.sv
// tb/tb_fp_cvt_128_to_i128.sv - scoreboard bench for fp_cvt_128_to_i128: directed cases, backpressure, reset
module tb_fp_cvt_128_to_i128;
  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   npush = 0;
  int   npop = 0;
  int   ndisc = 0;

  fp_cvt_128_to_i128_if bus ();

  fp_cvt_128_to_i128 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] o;
    logic         inx;
    logic         inv;
    logic         lat;
    int           acc;
    string        tag;
  } exp_t;

  exp_t sbq[$];

  localparam logic [127:0] IND   = {1'b1, 127'b0};
  localparam logic [127:0] SMAX  = {1'b0, {127{1'b1}}};
  localparam logic [127:0] UMAX  = {128{1'b1}};
  localparam logic [127:0] NEG2  = {{126{1'b1}}, 2'b10};
  localparam logic [127:0] NEG3  = {{126{1'b1}}, 2'b01};

  function automatic logic [127:0] sat_or_ind(input logic [127:0] satv);
`ifdef FPCVTTOI_SAT_EN
    return satv;
`else
    return (satv === satv) ? IND : IND;
`endif
  endfunction

  function automatic logic [127:0] i2f(input longint v);
    logic [63:0]  m;
    logic [175:0] t;
    logic [127:0] r;
    int           p;
    if (v == 0) return '0;
    m = (v < 0) ? 64'(-v) : 64'(v);
    p = 63;
    while (!m[p]) p--;
    t = {112'b0, m} << (112 - p);
    r = '0;
    r[127] = (v < 0);
    r[126:112] = 15'(16383 + p);
    r[111:0] = t[111:0];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input string tag, input logic [127:0] av, input logic opv, input logic [2:0] rmv,
                      input logic [127:0] eo, input logic einx, input logic einv, input logic lat);
    exp_t e;
    int   n;
    bus.vld_i = 1'b1;
    bus.a     = av;
    bus.op    = opv;
    bus.rm    = rmv;
    n = 0;
    @(negedge clk);
    while (!bus.rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 128'(bus.rdy_o), 128'(1));
    if (bus.rdy_o) begin
      e.o = eo; e.inx = einx; e.inv = einv; e.lat = lat; e.acc = cyc; e.tag = tag;
      sbq.push_back(e);
      npush++;
    end
    @(posedge clk);
    #1;
    bus.vld_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 128'(sbq.size()), 128'(0));
  endtask

  // Output monitor: pops on handshake, checks stability while stalled.
  initial begin
    logic         hold_v;
    logic [127:0] hold_o;
    exp_t         e;
    hold_v = 1'b0;
    hold_o = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_vld_o", 128'(bus.vld_o), 128'(1));
          check("stall_o", bus.o, hold_o);
        end
        if (bus.vld_o && !(bus.rdy_i && ce)) begin
          hold_v = 1'b1;
          hold_o = bus.o;
        end else begin
          hold_v = 1'b0;
        end
        if (bus.vld_o && bus.rdy_i && ce) begin
          check("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            npop++;
            check({e.tag, "_o"}, bus.o, e.o);
            check({e.tag, "_inexact"}, 128'(bus.inexact), 128'(e.inx));
            check({e.tag, "_invalid"}, 128'(bus.invalid), 128'(e.inv));
            if (e.lat) check({e.tag, "_latency"}, 128'(cyc - e.acc), 128'(3));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    longint vals[8];
    vals = '{5, -3, 100, -1, 7, 0, 42, -9};
    bus.vld_i = 1'b0;
    bus.a     = '0;
    bus.op    = 1'b0;
    bus.rm    = 3'd0;
    bus.rdy_i = 1'b1;
    ce        = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld_o", 128'(bus.vld_o), 128'(0));
    check("rst_o", bus.o, 128'(0));
    check("rst_inexact", 128'(bus.inexact), 128'(0));
    check("rst_invalid", 128'(bus.invalid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("one", {16'h3FFF, 112'b0}, 1'b1, 3'd0, 128'(1), 1'b0, 1'b0, 1'b1);
    drain();

    send("m2p5_rne", {16'hC000, 16'h4000, 96'b0}, 1'b1, 3'd0, NEG2, 1'b1, 1'b0, 1'b1);
    send("m2p5_rtz", {16'hC000, 16'h4000, 96'b0}, 1'b1, 3'd1, NEG2, 1'b1, 1'b0, 1'b1);
    send("m2p5_rup", {16'hC000, 16'h4000, 96'b0}, 1'b1, 3'd2, NEG2, 1'b1, 1'b0, 1'b1);
    send("m2p5_rdn", {16'hC000, 16'h4000, 96'b0}, 1'b1, 3'd3, NEG3, 1'b1, 1'b0, 1'b1);
    send("m2p5_rmm", {16'hC000, 16'h4000, 96'b0}, 1'b1, 3'd4, NEG3, 1'b1, 1'b0, 1'b1);
    send("p2_127_u", {16'h407E, 112'b0}, 1'b0, 3'd0, IND, 1'b0, 1'b0, 1'b1);
    send("p2_127_s", {16'h407E, 112'b0}, 1'b1, 3'd0, sat_or_ind(SMAX), 1'b0, 1'b1, 1'b1);
    send("m0p25_rne", {16'hBFFD, 112'b0}, 1'b0, 3'd0, 128'(0), 1'b1, 1'b0, 1'b1);
    send("m0p25_rdn", {16'hBFFD, 112'b0}, 1'b0, 3'd3, sat_or_ind(128'(0)), 1'b0, 1'b1, 1'b1);
    send("nan_s", {16'h7FFF, 16'h8000, 96'b0}, 1'b1, 3'd0, sat_or_ind(SMAX), 1'b0, 1'b1, 1'b1);
    send("m2_127_s", {16'hC07E, 112'b0}, 1'b1, 3'd0, IND, 1'b0, 1'b0, 1'b1);
    send("p2_128_u", {16'h407F, 112'b0}, 1'b0, 3'd0, sat_or_ind(UMAX), 1'b0, 1'b1, 1'b1);
    send("ninf_u", {16'hFFFF, 112'b0}, 1'b0, 3'd0, sat_or_ind(128'(0)), 1'b0, 1'b1, 1'b1);
    send("umax_exact", {16'h407E, {112{1'b1}}}, 1'b0, 3'd1, {{113{1'b1}}, 15'b0}, 1'b0, 1'b0, 1'b1);
    send("tiny_rup", 128'h1, 1'b1, 3'd2, 128'(1), 1'b1, 1'b0, 1'b1);
    send("tiny_rne", 128'h1, 1'b1, 3'd0, 128'(0), 1'b1, 1'b0, 1'b1);
    send("half_rne", {16'h3FFE, 112'b0}, 1'b1, 3'd0, 128'(0), 1'b1, 1'b0, 1'b1);
    send("half_rmm", {16'h3FFE, 112'b0}, 1'b1, 3'd4, 128'(1), 1'b1, 1'b0, 1'b1);
    send("onehalf_rne", {16'h3FFF, 16'h8000, 96'b0}, 1'b1, 3'd0, 128'(2), 1'b1, 1'b0, 1'b1);
    send("zero_rup", 128'h0, 1'b1, 3'd2, 128'(0), 1'b0, 1'b0, 1'b1);
    drain();

    fork
      begin
        for (int k = 0; k < 8; k++)
          send($sformatf("stream%0d", k), i2f(vals[k]), 1'b1, 3'd1,
               {{64{vals[k][63]}}, vals[k]}, 1'b0, 1'b0, 1'b0);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          bus.rdy_i = (i % 4 == 0) || (i % 4 == 3);
          ce = (i != 6);
          @(posedge clk);
          #1;
        end
        bus.rdy_i = 1'b1;
        ce = 1'b1;
      end
    join
    drain();

    send("pre_rst0", i2f(11), 1'b1, 3'd1, 128'(11), 1'b0, 1'b0, 1'b1);
    send("pre_rst1", i2f(12), 1'b1, 3'd1, 128'(12), 1'b0, 1'b0, 1'b1);
    send("pre_rst2", i2f(13), 1'b1, 3'd1, 128'(13), 1'b0, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_vld_o", 128'(bus.vld_o), 128'(0));
    check("midrst_o", bus.o, 128'(0));
    check("midrst_invalid", 128'(bus.invalid), 128'(0));
    ndisc += sbq.size();
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy_o", 128'(bus.rdy_o), 128'(1));
    @(posedge clk);
    #1;
    send("post_rst_one", {16'h3FFF, 112'b0}, 1'b1, 3'd0, 128'(1), 1'b0, 1'b0, 1'b1);
    drain();
    repeat (4) @(posedge clk);
    check("pop_count", 128'(npop), 128'(npush - ndisc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
